// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier: one partial product per clock, WIDTH+1 cycle latency.
// Optional macro SEQ_MULT_SIGNED_EN selects two's-complement operands and product.
module seq_shift_add_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   acc_d;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   mcand_init;
  logic [CW-1:0]   count_q;
  logic            last_step;
  logic            load;
  logic            busy_d;
  logic            done_d;

  assign last_step = (count_q == LAST_COUNT);
  // New operands are taken whenever the FSM is not mid-multiply (IDLE or DONE).
  assign load      = (state_q != RUN) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // Partial-product step; in signed mode the MSB weight of b is negative.
  always_comb begin
    addend = mplier_q[0] ? mcand_q : '0;
`ifdef SEQ_MULT_SIGNED_EN
    acc_d      = last_step ? (acc_q - addend) : (acc_q + addend);
    mcand_init = {{WIDTH{a[WIDTH-1]}}, a};
`else
    acc_d      = acc_q + addend;
    mcand_init = {{WIDTH{1'b0}}, a};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      product  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (load) begin
        mcand_q  <= mcand_init;
        mplier_q <= b;
        acc_q    <= '0;
        count_q  <= '0;
      end else if (state_q == RUN) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        count_q  <= count_q + CW'(1);
        if (last_step) begin
          product <= acc_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult: WIDTH=8 directed vectors and WIDTH=4 exhaustive sweep.
// Expected values follow SEQ_MULT_SIGNED_EN when it is defined.
module tb_seq_shift_add_mult;

  typedef struct {
    logic [15:0] exp;
    int          c0;
  } exp_t;

`ifdef SEQ_MULT_SIGNED_EN
  localparam logic [15:0] E_FFFF = 16'h0001;
  localparam logic [15:0] E_807F = 16'hC080;
  localparam logic [15:0] E_8080 = 16'h4000;
  localparam logic [15:0] E_FD05 = 16'hFFF1;
`else
  localparam logic [15:0] E_FFFF = 16'hFE01;
  localparam logic [15:0] E_807F = 16'h3F80;
  localparam logic [15:0] E_8080 = 16'h4000;
  localparam logic [15:0] E_FD05 = 16'h04F1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic        start4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  prod4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q8[$];
  exp_t q4[$];
  logic [15:0] last_prod8;
  logic [7:0]  last_prod4;
  int run8 = 0;
  int run4 = 0;
  int last_done4 = -1;

  seq_shift_add_mult #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  seq_shift_add_mult #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref4(input int x, input int y);
    int sx;
    int sy;
    sx = x;
    sy = y;
`ifdef SEQ_MULT_SIGNED_EN
    if (sx > 7) sx -= 16;
    if (sy > 7) sy -= 16;
`endif
    return 8'(sx * sy);
  endfunction

  task automatic go8(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
    exp_t item;
    a8 = x;
    b8 = y;
    start8 = 1'b1;
    item.exp = e;
    item.c0  = cyc;
    q8.push_back(item);
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  task automatic go4(input logic [3:0] x, input logic [3:0] y);
    exp_t item;
    a4 = x;
    b4 = y;
    start4 = 1'b1;
    item.exp = {8'h00, ref4(int'(x), int'(y))};
    item.c0  = cyc;
    q4.push_back(item);
    @(posedge clk);
    #1 start4 = 1'b0;
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    if (!done8) chk("timeout_done8", 32'(done8), 32'd1);
  endtask

  task automatic wait_done4();
    int n = 0;
    while (!done4 && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    if (!done4) chk("timeout_done4", 32'(done4), 32'd1);
  endtask

  // Monitor for the WIDTH=8 instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_prod8 = '0;
      run8 = 0;
    end else begin
      if (busy8) run8++;
      if (busy8 && done8) chk("busy8_and_done8", 32'd1, 32'd0);
      if (done8) begin
        if (q8.size() == 0) begin
          chk("unexpected_done8", 32'(done8), 32'd0);
        end else begin
          e = q8.pop_front();
          chk("product8", 32'(prod8), 32'(e.exp));
          chk("latency8", 32'(cyc - e.c0), 32'd9);
          chk("busy_len8", 32'(run8), 32'd8);
          last_prod8 = e.exp;
        end
        run8 = 0;
      end else begin
        chk("hold8", 32'(prod8), 32'(last_prod8));
      end
    end
  end

  // Monitor for the WIDTH=4 instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_prod4 = '0;
      run4 = 0;
      last_done4 = -1;
    end else begin
      if (busy4) run4++;
      if (busy4 && done4) chk("busy4_and_done4", 32'd1, 32'd0);
      if (done4) begin
        if (q4.size() == 0) begin
          chk("unexpected_done4", 32'(done4), 32'd0);
        end else begin
          e = q4.pop_front();
          chk("product4", 32'(prod4), 32'(e.exp[7:0]));
          chk("latency4", 32'(cyc - e.c0), 32'd5);
          chk("busy_len4", 32'(run4), 32'd4);
          if (last_done4 >= 0) chk("spacing4", 32'(cyc - last_done4), 32'd5);
          last_done4 = cyc;
          last_prod4 = e.exp[7:0];
        end
        run4 = 0;
      end else begin
        chk("hold4", 32'(prod4), 32'(last_prod4));
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    start8 = 1'b0;
    start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy8", 32'(busy8), 32'd0);
    chk("reset_done8", 32'(done8), 32'd0);
    chk("reset_prod8", 32'(prod8), 32'd0);
    chk("reset_prod4", 32'(prod4), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    go8(8'd15, 8'd15, 16'd225);
    wait_done8();
    repeat (3) @(posedge clk);
    #1;
    go8(8'hFF, 8'hFF, E_FFFF);
    wait_done8();
    repeat (2) @(posedge clk);
    #1;
    go8(8'h00, 8'hA5, 16'h0000);
    wait_done8();
    @(posedge clk);
    #1;

    // Back-to-back issue with a stray start mid-RUN that must be ignored
    go8(8'd3, 8'd7, 16'd21);
    repeat (3) @(posedge clk);
    #1;
    a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    wait_done8();
    go8(8'd12, 8'd11, 16'd132);
    wait_done8();
    go8(8'h80, 8'h7F, E_807F);
    wait_done8();
    go8(8'h80, 8'h80, E_8080);
    wait_done8();
    go8(8'hFD, 8'h05, E_FD05);
    wait_done8();
    @(posedge clk);
    #1;

    // Reset during the 4th RUN cycle aborts the multiply
    go8(8'd200, 8'd200, 16'd40000);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_run_busy8", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy8", 32'(busy8), 32'd0);
    chk("abort_done8", 32'(done8), 32'd0);
    chk("abort_prod8", 32'(prod8), 32'd0);
    q8.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    go8(8'd5, 8'd6, 16'd30);
    wait_done8();
    @(posedge clk);
    #1;

    // Exhaustive WIDTH=4 sweep, each op issued in the previous DONE cycle
    for (int i = 0; i < 256; i++) begin
      if (i > 0) wait_done4();
      go4(4'(i >> 4), 4'(i));
    end
    wait_done4();
    repeat (3) @(posedge clk);
    #1;

    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
